// File: rtl/alu_bsr_pkg.sv
// -----------------------------------------------------------------------------
// alu_bsr_pkg
// Shared definitions for the boundary-scan register chain that wraps the
// simpleALU core.
//   - instr_e      : TAP instruction encoding seen on InstrIn
//   - chain_len()  : number of boundary cells for a given operand/opcode width
//   - *_lsb()      : bit offset of each field inside the scan/update registers
//   - CHAIN_LEN, A_LSB, B_LSB, OP_LSB, RES_LSB : the same values at the
//     default widths (8-bit operands, 4-bit opcode)
//   - decode helpers that turn an instruction into mux selects
// -----------------------------------------------------------------------------
package alu_bsr_pkg;

  typedef enum logic [1:0] {
    INSTR_BYPASS         = 2'b00,
    INSTR_SAMPLE_PRELOAD = 2'b01,
    INSTR_EXTEST         = 2'b10,
    INSTR_INTEST         = 2'b11
  } instr_e;

  localparam int OPERAND_WIDTH_DEF = 8;
  localparam int OP_WIDTH_DEF      = 4;

  // Chain layout, LSB first: A operand, B operand, opcode, result (one bit
  // wider than an operand to hold the carry/borrow).
  function automatic int chain_len(input int ow, input int opw);
    return 3 * ow + opw + 1;
  endfunction

  function automatic int a_lsb();
    return 0;
  endfunction

  function automatic int b_lsb(input int ow);
    return ow;
  endfunction

  function automatic int op_lsb(input int ow);
    return 2 * ow;
  endfunction

  function automatic int res_lsb(input int ow, input int opw);
    return 2 * ow + opw;
  endfunction

  localparam int CHAIN_LEN = chain_len(OPERAND_WIDTH_DEF, OP_WIDTH_DEF);
  localparam int A_LSB     = a_lsb();
  localparam int B_LSB     = b_lsb(OPERAND_WIDTH_DEF);
  localparam int OP_LSB    = op_lsb(OPERAND_WIDTH_DEF);
  localparam int RES_LSB   = res_lsb(OPERAND_WIDTH_DEF, OP_WIDTH_DEF);

  // Every instruction except BYPASS routes the data register path through
  // the boundary chain.
  function automatic logic uses_chain(input instr_e instr);
    return instr != INSTR_BYPASS;
  endfunction

  // Core-side cells (A, B, OP) drive from the update register only in INTEST.
  function automatic logic core_from_update(input instr_e instr);
    return instr == INSTR_INTEST;
  endfunction

  // Pin-side cells (result) drive from the update register in EXTEST and INTEST.
  function automatic logic pins_from_update(input instr_e instr);
    return (instr == INSTR_EXTEST) || (instr == INSTR_INTEST);
  endfunction

endpackage

// File: rtl/alu_boundary_scan_bsc_cell.sv
// -----------------------------------------------------------------------------
// bsc_cell
// One boundary-scan cell: a shift-register bit, an update-register bit and the
// functional-path mux.
// Ports:
//   tck         in   test clock
//   reset       in   synchronous active-high reset, clears both bits
//   capture_en  in   load the shift bit from par_in (wins over shift_en)
//   shift_en    in   load the shift bit from scan_in
//   update_en   in   copy the pre-edge shift bit into the update bit
//   scan_in     in   serial input from the next cell towards TDI
//   par_in      in   functional value (pin or core side) being observed
//   sel_update  in   1: par_out driven by the update bit, 0: transparent
//   scan_out    out  shift bit, feeds the previous cell towards TDO
//   par_out     out  functional output
// -----------------------------------------------------------------------------
module bsc_cell (
  input  logic tck,
  input  logic reset,
  input  logic capture_en,
  input  logic shift_en,
  input  logic update_en,
  input  logic scan_in,
  input  logic par_in,
  input  logic sel_update,
  output logic scan_out,
  output logic par_out
);

  logic sr_d, sr_q;
  logic ur_d, ur_q;

  always_comb begin
    sr_d = sr_q;
    if (capture_en) begin
      sr_d = par_in;
    end else if (shift_en) begin
      sr_d = scan_in;
    end
  end

  // Update reads sr_q, so a simultaneous capture/shift still hands the old
  // shift bit to the update register.
  always_comb begin
    ur_d = ur_q;
    if (update_en) begin
      ur_d = sr_q;
    end
  end

  always_ff @(posedge tck) begin
    if (reset) begin
      sr_q <= 1'b0;
      ur_q <= 1'b0;
    end else begin
      sr_q <= sr_d;
      ur_q <= ur_d;
    end
  end

  assign scan_out = sr_q;
  assign par_out  = sel_update ? ur_q : par_in;

endmodule

// File: rtl/alu_boundary_scan.sv
// -----------------------------------------------------------------------------
// alu_boundary_scan
// Boundary-scan register chain placed between the chip pins and the simpleALU
// core. Lets the TAP preload, apply and capture ALU vectors.
// Ports:
//   TCK            in   test clock (only clock)
//   Reset          in   synchronous active-high reset
//   TDIin          in   serial scan input
//   TDOout         out  serial scan output (bypass bit or chain bit 0)
//   InstrIn        in   00 BYPASS, 01 SAMPLE_PRELOAD, 10 EXTEST, 11 INTEST
//   CaptureDRin    in   capture strobe
//   ShiftDRin      in   shift strobe
//   UpdateDRin     in   update strobe
//   PinAin/PinBin  in   operand pins
//   PinOPin        in   opcode pins
//   PinResultout   out  result pins
//   CoreAout/CoreBout/CoreOPout  out  to ALU Ain/Bin/OPin
//   CoreResultin   in   from ALU Resultout
// -----------------------------------------------------------------------------
module alu_boundary_scan
  import alu_bsr_pkg::*;
#(
  parameter int OPERAND_WIDTH = 8,
  parameter int OP_WIDTH      = 4
) (
  input  logic                     TCK,
  input  logic                     Reset,
  input  logic                     TDIin,
  output logic                     TDOout,
  input  logic [1:0]               InstrIn,
  input  logic                     CaptureDRin,
  input  logic                     ShiftDRin,
  input  logic                     UpdateDRin,
  input  logic [OPERAND_WIDTH-1:0] PinAin,
  input  logic [OPERAND_WIDTH-1:0] PinBin,
  input  logic [OP_WIDTH-1:0]      PinOPin,
  output logic [OPERAND_WIDTH:0]   PinResultout,
  output logic [OPERAND_WIDTH-1:0] CoreAout,
  output logic [OPERAND_WIDTH-1:0] CoreBout,
  output logic [OP_WIDTH-1:0]      CoreOPout,
  input  logic [OPERAND_WIDTH:0]   CoreResultin
);

  localparam int L       = chain_len(OPERAND_WIDTH, OP_WIDTH);
  localparam int A_OFF   = a_lsb();
  localparam int B_OFF   = b_lsb(OPERAND_WIDTH);
  localparam int OP_OFF  = op_lsb(OPERAND_WIDTH);
  localparam int RES_OFF = res_lsb(OPERAND_WIDTH, OP_WIDTH);

  instr_e instr;
  logic   chain_sel;
  logic   core_sel_ur;
  logic   pins_sel_ur;
  logic   cap_chain;
  logic   shift_chain;
  logic   upd_chain;

  assign instr       = instr_e'(InstrIn);
  assign chain_sel   = uses_chain(instr);
  assign core_sel_ur = core_from_update(instr);
  assign pins_sel_ur = pins_from_update(instr);

  // In BYPASS the chain holds; the strobes only reach the bypass bit.
  assign cap_chain   = CaptureDRin & chain_sel;
  assign shift_chain = ShiftDRin & chain_sel;
  assign upd_chain   = UpdateDRin & chain_sel;

  // Parallel vectors share the chain bit map. Each cell observes the value on
  // its functional input, which is also what it passes through when
  // transparent: pins for A/B/OP, the core result for the result field.
  logic [L-1:0] par_in_vec;
  logic [L-1:0] par_out_vec;
  logic [L-1:0] sel_vec;
  logic [L-1:0] sr_vec;
  logic [L-1:0] scan_in_vec;

  assign par_in_vec  = {CoreResultin, PinOPin, PinBin, PinAin};
  assign sel_vec     = {{(L - RES_OFF){pins_sel_ur}}, {RES_OFF{core_sel_ur}}};

  // TDI enters at the result MSB; bit 0 (A[0]) is the cell next to TDO.
  assign scan_in_vec = {TDIin, sr_vec[L-1:1]};

  for (genvar i = 0; i < L; i++) begin : g_cell
    bsc_cell u_cell (
      .tck        (TCK),
      .reset      (Reset),
      .capture_en (cap_chain),
      .shift_en   (shift_chain),
      .update_en  (upd_chain),
      .scan_in    (scan_in_vec[i]),
      .par_in     (par_in_vec[i]),
      .sel_update (sel_vec[i]),
      .scan_out   (sr_vec[i]),
      .par_out    (par_out_vec[i])
    );
  end

  assign CoreAout     = par_out_vec[B_OFF-1:A_OFF];
  assign CoreBout     = par_out_vec[OP_OFF-1:B_OFF];
  assign CoreOPout    = par_out_vec[RES_OFF-1:OP_OFF];
  assign PinResultout = par_out_vec[L-1:RES_OFF];

  logic byp_d, byp_q;

  always_comb begin
    byp_d = byp_q;
    if (!chain_sel) begin
      if (CaptureDRin) begin
        byp_d = 1'b0;
      end else if (ShiftDRin) begin
        byp_d = TDIin;
      end
    end
  end

  always_ff @(posedge TCK) begin
    if (Reset) begin
      byp_q <= 1'b0;
    end else begin
      byp_q <= byp_d;
    end
  end

  assign TDOout = chain_sel ? sr_vec[0] : byp_q;

endmodule

// File: tb/tb_alu_boundary_scan.sv
`timescale 1ns/1ps
module tb_alu_boundary_scan;
  import alu_bsr_pkg::*;

  localparam int W  = OPERAND_WIDTH_DEF;
  localparam int OW = OP_WIDTH_DEF;
  localparam int L  = CHAIN_LEN;
  localparam int RW = W + 1;

  localparam int SIG_TDO = 0;
  localparam int SIG_CA  = 1;
  localparam int SIG_CB  = 2;
  localparam int SIG_COP = 3;
  localparam int SIG_PR  = 4;

  logic          TCK = 1'b0;
  logic          Reset;
  logic          TDIin;
  logic          TDOout;
  logic [1:0]    InstrIn;
  logic          CaptureDRin, ShiftDRin, UpdateDRin;
  logic [W-1:0]  PinAin, PinBin, CoreAout, CoreBout;
  logic [OW-1:0] PinOPin, CoreOPout;
  logic [RW-1:0] PinResultout, CoreResultin, res_drv;
  logic          alu_attached;

  always #5 TCK = ~TCK;

  alu_boundary_scan #(.OPERAND_WIDTH(W), .OP_WIDTH(OW)) dut (
    .TCK(TCK), .Reset(Reset), .TDIin(TDIin), .TDOout(TDOout), .InstrIn(InstrIn),
    .CaptureDRin(CaptureDRin), .ShiftDRin(ShiftDRin), .UpdateDRin(UpdateDRin),
    .PinAin(PinAin), .PinBin(PinBin), .PinOPin(PinOPin), .PinResultout(PinResultout),
    .CoreAout(CoreAout), .CoreBout(CoreBout), .CoreOPout(CoreOPout),
    .CoreResultin(CoreResultin)
  );

  // Stand-in for the simpleALU core when it is attached behind the chain.
  function automatic logic [RW-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [OW-1:0] op);
    case (op)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {1'b0, a} - {1'b0, b};
      4'd2:    return {1'b0, a & b};
      4'd3:    return {1'b0, a | b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  assign CoreResultin = alu_attached ? alu_fn(CoreAout, CoreBout, CoreOPout) : res_drv;

  // ---------------- reference model ----------------
  logic [L-1:0] m_sr, m_ur;
  logic         m_byp;

  function automatic logic [W-1:0] exp_a();
    return (InstrIn == 2'b11) ? m_ur[B_LSB-1:A_LSB] : PinAin;
  endfunction
  function automatic logic [W-1:0] exp_b();
    return (InstrIn == 2'b11) ? m_ur[OP_LSB-1:B_LSB] : PinBin;
  endfunction
  function automatic logic [OW-1:0] exp_op();
    return (InstrIn == 2'b11) ? m_ur[RES_LSB-1:OP_LSB] : PinOPin;
  endfunction
  function automatic logic [RW-1:0] exp_core_res();
    return alu_attached ? alu_fn(exp_a(), exp_b(), exp_op()) : res_drv;
  endfunction
  function automatic logic [RW-1:0] exp_pin_res();
    if (InstrIn == 2'b10 || InstrIn == 2'b11) return m_ur[L-1:RES_LSB];
    return exp_core_res();
  endfunction
  function automatic logic exp_tdo();
    return (InstrIn == 2'b00) ? m_byp : m_sr[0];
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    string       name;
    int          sig;
    logic [31:0] exp;
  } chk_t;

  chk_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void push(input string name, input int sig, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.sig  = sig;
    c.exp  = exp;
    sb_q.push_back(c);
  endfunction

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      SIG_TDO: return 32'(TDOout);
      SIG_CA:  return 32'(CoreAout);
      SIG_CB:  return 32'(CoreBout);
      SIG_COP: return 32'(CoreOPout);
      default: return 32'(PinResultout);
    endcase
  endfunction

  always @(negedge TCK) begin : monitor
    chk_t        c;
    logic [31:0] act;
    while (sb_q.size() > 0) begin
      c   = sb_q.pop_front();
      act = observe(c.sig);
      checks++;
      if (act !== c.exp) begin
        errors++;
        $display("FAIL %s at %0t: got %0h expected %0h", c.name, $time, act, c.exp);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    logic [L-1:0]  nsr, nur;
    logic          nbyp;
    logic [RW-1:0] cres;
    push("tdo",     SIG_TDO, 32'(exp_tdo()));
    push("core_a",  SIG_CA,  32'(exp_a()));
    push("core_b",  SIG_CB,  32'(exp_b()));
    push("core_op", SIG_COP, 32'(exp_op()));
    push("pin_res", SIG_PR,  32'(exp_pin_res()));
    cres = exp_core_res();
    nsr  = m_sr;
    nur  = m_ur;
    nbyp = m_byp;
    if (Reset) begin
      nsr  = '0;
      nur  = '0;
      nbyp = 1'b0;
    end else if (InstrIn == 2'b00) begin
      if (CaptureDRin)    nbyp = 1'b0;
      else if (ShiftDRin) nbyp = TDIin;
    end else begin
      if (CaptureDRin)    nsr = {cres, PinOPin, PinBin, PinAin};
      else if (ShiftDRin) nsr = {TDIin, m_sr[L-1:1]};
      if (UpdateDRin)     nur = m_sr;
    end
    @(posedge TCK);
    #1;
    m_sr  = nsr;
    m_ur  = nur;
    m_byp = nbyp;
  endtask

  task automatic idle();
    Reset       = 1'b0;
    CaptureDRin = 1'b0;
    ShiftDRin   = 1'b0;
    UpdateDRin  = 1'b0;
  endtask

  task automatic load_and_update(input logic [L-1:0] v);
    for (int i = 0; i < L; i++) begin
      TDIin     = v[i];
      ShiftDRin = 1'b1;
      cyc();
    end
    ShiftDRin  = 1'b0;
    UpdateDRin = 1'b1;
    cyc();
    UpdateDRin = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0]    pat_a5;
    logic [RW-1:0] res8;
    logic [3:0]    byp_in, byp_out;

    Reset = 1'b1; CaptureDRin = 0; ShiftDRin = 0; UpdateDRin = 0; TDIin = 0;
    InstrIn = 2'b11; PinAin = 8'h5A; PinBin = 8'hC3; PinOPin = 4'h7;
    res_drv = 9'h000; alu_attached = 1'b0;
    @(posedge TCK);
    #1;
    m_sr = '0; m_ur = '0; m_byp = 1'b0;
    idle();

    // INTEST load: A=0x05, B=0x03, OP=0
    InstrIn = 2'b11;
    load_and_update({9'h000, 4'h0, 8'h03, 8'h05});
    push("intest_load_a",  SIG_CA,  32'h05);
    push("intest_load_b",  SIG_CB,  32'h03);
    push("intest_load_op", SIG_COP, 32'h0);
    cyc();

    // INTEST capture with the ALU attached: 5 + 3 = 0x008 on shifts 20..28
    alu_attached = 1'b1;
    res8 = 9'h008;
    CaptureDRin = 1'b1;
    cyc();
    CaptureDRin = 1'b0;
    for (int i = 0; i < L; i++) begin
      if (i >= RES_LSB) push("intest_cap_res_bit", SIG_TDO, 32'(res8[i - RES_LSB]));
      TDIin     = 1'($urandom_range(1));
      ShiftDRin = 1'b1;
      cyc();
    end
    idle();

    // Reset mid-shift
    for (int i = 0; i < 7; i++) begin
      TDIin     = 1'b1;
      ShiftDRin = 1'b1;
      cyc();
    end
    Reset = 1'b1;
    cyc();
    idle();
    alu_attached = 1'b0;
    res_drv = 9'h0AA;
    push("rst_tdo",     SIG_TDO, 32'h0);
    push("rst_core_a",  SIG_CA,  32'h0);
    push("rst_core_b",  SIG_CB,  32'h0);
    push("rst_core_op", SIG_COP, 32'h0);
    push("rst_pin_res", SIG_PR,  32'h0);
    cyc();

    // SAMPLE_PRELOAD: capture pins, shift out A LSB first
    InstrIn = 2'b01;
    PinAin = 8'hA5; PinBin = 8'h3C; PinOPin = 4'h2;
    pat_a5 = 8'hA5;
    CaptureDRin = 1'b1;
    cyc();
    CaptureDRin = 1'b0;
    push("sp_core_a",  SIG_CA,  32'hA5);
    push("sp_core_b",  SIG_CB,  32'h3C);
    push("sp_core_op", SIG_COP, 32'h2);
    push("sp_pin_res", SIG_PR,  32'h0AA);
    for (int i = 0; i < 8; i++) begin
      push("sp_tdo_bit", SIG_TDO, 32'(pat_a5[i]));
      TDIin     = 1'b0;
      ShiftDRin = 1'b1;
      cyc();
    end
    idle();

    // EXTEST: preload result 0x1FF, drive it onto the pins
    load_and_update({9'h1FF, 4'h0, 8'h00, 8'h00});
    InstrIn = 2'b10;
    res_drv = 9'h000;
    push("extest_pin_res", SIG_PR, 32'h1FF);
    push("extest_core_a",  SIG_CA, 32'hA5);
    cyc();

    // BYPASS: one-cycle delay through BYP, UR untouched even with update pulses
    InstrIn = 2'b00;
    CaptureDRin = 1'b1;
    cyc();
    CaptureDRin = 1'b0;
    byp_in  = 4'b1101;   // shifted in bit 0 first: 1,0,1,1
    byp_out = 4'b1010;   // observed bit 0 first:   0,1,0,1
    for (int i = 0; i < 4; i++) begin
      push("byp_tdo", SIG_TDO, 32'(byp_out[i]));
      TDIin      = byp_in[i];
      ShiftDRin  = 1'b1;
      UpdateDRin = 1'(i % 2);
      cyc();
    end
    idle();
    InstrIn = 2'b11;
    push("byp_ur_core_a",  SIG_CA,  32'h00);
    push("byp_ur_core_op", SIG_COP, 32'h0);
    push("byp_ur_pin_res", SIG_PR,  32'h1FF);
    cyc();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(19) == 0) InstrIn = 2'($urandom_range(3));
      if ($urandom_range(29) == 0) alu_attached = ~alu_attached;
      Reset       = ($urandom_range(49) == 0);
      CaptureDRin = ($urandom_range(3) == 0);
      ShiftDRin   = 1'($urandom_range(1));
      UpdateDRin  = ($urandom_range(5) == 0);
      TDIin       = 1'($urandom_range(1));
      PinAin      = 8'($urandom);
      PinBin      = 8'($urandom);
      PinOPin     = 4'($urandom);
      res_drv     = 9'($urandom);
      cyc();
    end

    // Idle strobes freeze state
    idle();
    for (int n = 0; n < 8; n++) cyc();

    repeat (2) @(negedge TCK);
    #1;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
